// File: rtl/insn_fetch_queue.sv
// insn_fetch_queue: decoupling FIFO between fetch and the RISC-V decoder.
// Each entry holds one instruction plus its branch-prediction metadata.
// The head entry is presented first-word-fall-through with a valid/ready handshake.
// A flush empties the queue in a single cycle.
// Optional feature macro: FETCH_Q_CYCLE_ACCT_EN adds a per-entry fetch cycle stamp.
module insn_fetch_queue #(
    parameter int unsigned LG_DEPTH = 3,
    parameter int unsigned W        = 64,
    parameter int unsigned LG_PHT   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                enq_valid,
    output logic                enq_ready,
    input  logic [31:0]         enq_insn,
    input  logic [W-1:0]        enq_pc,
    input  logic                enq_pred,
    input  logic [LG_PHT-1:0]   enq_pht_idx,
    input  logic [W-1:0]        enq_pred_target,
    output logic                deq_valid,
    input  logic                deq_ready,
    output logic [31:0]         deq_insn,
    output logic [W-1:0]        deq_pc,
    output logic                deq_pred,
    output logic [LG_PHT-1:0]   deq_pht_idx,
    output logic [W-1:0]        deq_pred_target,
`ifdef FETCH_Q_CYCLE_ACCT_EN
    input  logic [63:0]         enq_fetch_cycle,
    output logic [63:0]         deq_fetch_cycle,
`endif
    output logic [LG_DEPTH:0]   occupancy
);

    localparam int unsigned DEPTH = 1 << LG_DEPTH;
    localparam int unsigned PW    = LG_DEPTH + 1;

    typedef struct packed {
        logic [31:0]       insn;
        logic [W-1:0]      pc;
        logic              pred;
        logic [LG_PHT-1:0] pht_idx;
        logic [W-1:0]      pred_target;
`ifdef FETCH_Q_CYCLE_ACCT_EN
        logic [63:0]       fetch_cycle;
`endif
    } entry_t;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    entry_t        mem [DEPTH];
    entry_t        wr_entry;
    entry_t        rd_entry;
    logic          empty;
    logic          full;
    logic          enq_fire;
    logic          deq_fire;

    // Status and handshake decode from the registered pointers only
    always_comb begin
        empty     = (head == tail);
        full      = (head[LG_DEPTH-1:0] == tail[LG_DEPTH-1:0]) &&
                    (head[LG_DEPTH] != tail[LG_DEPTH]);
        enq_ready = !full;
        deq_valid = !empty;
        enq_fire  = enq_valid && enq_ready;
        deq_fire  = deq_valid && deq_ready;
        occupancy = tail - head;
    end

    // Pack the incoming payload
    always_comb begin
        wr_entry             = '0;
        wr_entry.insn        = enq_insn;
        wr_entry.pc          = enq_pc;
        wr_entry.pred        = enq_pred;
        wr_entry.pht_idx     = enq_pht_idx;
        wr_entry.pred_target = enq_pred_target;
`ifdef FETCH_Q_CYCLE_ACCT_EN
        wr_entry.fetch_cycle = enq_fetch_cycle;
`endif
    end

    // First-word-fall-through read of the head entry
    always_comb begin
        rd_entry        = mem[head[LG_DEPTH-1:0]];
        deq_insn        = rd_entry.insn;
        deq_pc          = rd_entry.pc;
        deq_pred        = rd_entry.pred;
        deq_pht_idx     = rd_entry.pht_idx;
        deq_pred_target = rd_entry.pred_target;
`ifdef FETCH_Q_CYCLE_ACCT_EN
        deq_fetch_cycle = rd_entry.fetch_cycle;
`endif
    end

    // Head/tail pointers; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_fire) tail <= tail + PW'(1);
            if (deq_fire) head <= head + PW'(1);
        end
    end

    // Payload storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (enq_fire && !reset && !flush) mem[tail[LG_DEPTH-1:0]] <= wr_entry;
    end

`ifndef SYNTHESIS
    // Protocol checks: no enqueue counted while full, head never passes tail
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(enq_fire && full));
            assert (occupancy <= PW'(DEPTH));
            assert (!(deq_fire && empty));
        end
    end
`endif

endmodule

// File: doc/insn_fetch_queue.md
Name: insn_fetch_queue

Overview:
- Decoupling FIFO between the fetch unit and the RISC-V decoder.
- Stores one fetched instruction per entry, with its branch-prediction metadata: insn, pc, predicted-taken bit, PHT index and predicted target.
- Presents the oldest entry to decode with a valid/ready handshake.
- Supports a single-cycle flush on pipeline redirect (mispredict, exception, serializing restart).

Parameters:
- LG_DEPTH, 3, log2 of entry count (8 entries).
- W, 64, machine width; matches `M_WIDTH.
- LG_PHT, 16, PHT index width; matches `LG_PHT_SZ.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard all entries this cycle
- enq_valid  in  1  fetch presents an instruction
- enq_ready  out  1  queue can accept (not full)
- enq_insn  in  32  instruction word
- enq_pc  in  W  instruction PC
- enq_pred  in  1  predicted taken
- enq_pht_idx  in  LG_PHT  PHT index
- enq_pred_target  in  W  predicted target (jalr)
- deq_valid  out  1  head entry valid
- deq_ready  in  1  decode consumes head
- deq_insn  out  32  head instruction
- deq_pc  out  W  head PC
- deq_pred  out  1  head prediction
- deq_pht_idx  out  LG_PHT  head PHT index
- deq_pred_target  out  W  head predicted target
- occupancy  out  LG_DEPTH+1  entries held

Behaviour:
- Storage:
  - Circular buffer of 2^LG_DEPTH entries.
  - Head and tail pointers are LG_DEPTH+1 bits; the extra MSB is a wrap bit.
  - empty = (head == tail).
  - full = index bits equal and wrap bits differ.
- Outputs:
  - enq_ready = !full, driven combinationally from registered pointers only; no dependence on deq_ready.
  - deq_valid = !empty.
  - deq_* = entry[head index], read combinationally (first-word-fall-through).
- Handshake:
  - Enqueue fires when enq_valid && enq_ready: entry written at tail, tail increments.
  - Dequeue fires when deq_valid && deq_ready: head increments.
  - Both may fire in the same cycle; occupancy is then unchanged.
  - Full with deq_ready=1: enq_ready stays 0 that cycle; there is no same-cycle slot reuse.
- Latency:
  - An entry written in cycle N is visible on deq_* in cycle N+1.
  - There is no empty-queue bypass.
- Wrap-around:
  - Pointer increments are modulo 2^(LG_DEPTH+1).
  - The index wraps from 2^LG_DEPTH-1 to 0 and the wrap bit toggles.
- Occupancy: tail - head in LG_DEPTH+1 bits, registered-pointer derived; range 0..2^LG_DEPTH.
- Flush:
  - On a flush cycle, head and tail both set to 0 next cycle.
  - Any enqueue or dequeue in that cycle is discarded; flush has priority over enq_valid.
  - The fetch unit must redirect. Flush while empty is a no-op.
- Reset:
  - Same effect as flush.
  - Next cycle: deq_valid=0, enq_ready=1, occupancy=0.
  - Entry payload registers are not reset; deq_* data is don't-care while deq_valid=0.
  - Reset asserted mid-operation discards all entries identically.
- Protocol assertions (simulation only):
  - Enqueue attempted while full is never counted.
  - Head must never pass tail.

Optional Feature:
- FETCH_Q_CYCLE_ACCT_EN: adds input enq_fetch_cycle[63:0] and output deq_fetch_cycle[63:0], stored per entry alongside the other payload.
- With the macro defined: deq_fetch_cycle follows head exactly like deq_pc. The decoder copies it into uop.fetch_cycle for cycle accounting.
- Without the macro: the ports and storage are absent. All other behaviour is identical.

Test Plan:
- Reset, then idle → deq_valid=0, enq_ready=1, occupancy=0.
- Enqueue insn 0x00000013 with pc 0x1000 in cycle 5 → cycle 6: deq_valid=1, deq_insn=0x00000013, deq_pc=0x1000, occupancy=1.
- Enqueue 8 entries with deq_ready=0 (pc 0x1000..0x101c):
  - enq_ready=0 and occupancy=8 after the 8th.
  - A 9th enq_valid is ignored.
  - Then drain 8 with deq_ready=1 → pcs emerge in order 0x1000..0x101c, then deq_valid=0.
- Continuous enq+deq for 20 cycles at occupancy 3 → occupancy stays 3; pointers wrap twice; deq_pht_idx and deq_pred_target match enqueue order.
- Flush at occupancy 5 with enq_valid=1 in the same cycle → next cycle occupancy=0, deq_valid=0; the concurrent enqueue is dropped.
- Reset asserted with occupancy 4 while deq_ready=1 → next cycle empty. Then a new enqueue of pc 0x2000 → pc 0x2000 appears at the head one cycle later.
